mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a single-issue core and a word-wide data memory.
// Handles sub-word loads with extension, sub-word stores via read-modify-write, and fault detection.
module mem_access_unit #(
  parameter int MEM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_fault;
  logic [31:0] req_word;
  logic        is_store;
  logic [31:0] rd_shifted;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign req_word = {2'b00, req_addr[31:2]};

  always_comb begin
    req_misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         req_misaligned = |req_addr[1:0];
      OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
      default:              req_misaligned = 1'b0;
    endcase
    req_out_of_range = (req_word >= MEM_WORDS_W);
    req_fault        = req_misaligned | req_out_of_range;
  end

  assign is_store   = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
  assign rd_shifted = mem_rd >> {addr_q[1:0], 3'b000};
  assign rd_byte    = rd_shifted[7:0];
  assign rd_half    = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    load_data = 32'h0;
    case (op_q)
      OP_LW:   load_data = mem_rd;
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'h0, rd_half};
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h0, rd_byte};
      default: load_data = 32'h0;
    endcase
  end

  // Sub-word stores merge the new lane into the word currently read back from memory.
  always_comb begin
    store_data = wdata_q;
    case (op_q)
      OP_SH: store_data = addr_q[1] ? {wdata_q[15:0], mem_rd[15:0]}
                                    : {mem_rd[31:16], wdata_q[15:0]};
      OP_SB: begin
        case (addr_q[1:0])
          2'd0:    store_data = {mem_rd[31:8], wdata_q[7:0]};
          2'd1:    store_data = {mem_rd[31:16], wdata_q[7:0], mem_rd[7:0]};
          2'd2:    store_data = {mem_rd[31:24], wdata_q[7:0], mem_rd[15:0]};
          default: store_data = {wdata_q[7:0], mem_rd[23:0]};
        endcase
      end
      default: store_data = wdata_q;
    endcase
  end

  // Response registers only change on entry to RESP so they hold their last value while idle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          if (req_fault) begin
            state_d = RESP;
            fault_d = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        fault_d = 1'b0;
        rdata_d = is_store ? 32'h0 : load_data;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 3'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Write enable is gated by reset so an interrupted store never reaches memory.
  assign mem_we    = (state_q == ACCESS) && is_store && !reset;
  assign req_ready = (state_q == IDLE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wd    = store_data;
  assign mem_pc    = pc_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory attached.
// Expected values are hand-computed from the little-endian lane rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_pc;
  logic [31:0] mem_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  logic [31:0] mem [0:3071] = '{default: 32'h0};
  int          we_count = 0;
  logic [31:0] last_wd = 32'h0;
  int          assert_count = 0;
  int          fail_count = 0;

  mem_access_unit #(.MEM_WORDS(3072)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_pc    (mem_pc),
    .mem_rd    (mem_rd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_addr[31:2] < 30'd3072) ? mem[mem_addr[13:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      we_count <= we_count + 1;
      last_wd  <= mem_wd;
      if (mem_addr[31:2] < 30'd3072) mem[mem_addr[13:2]] <= mem_wd;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one request and waits (bounded) for the response; lat counts edges from accept to rsp_valid.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] pc, output int lat, output int writes);
    int we_before;
    we_before = we_count;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = pc;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    writes = we_count - we_before;
  endtask

  task automatic releaseResponse();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int writes;
    int we_snap;
    logic [31:0] held;

    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; req_pc = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);

    applyStimulus(3'd5, 32'h10, 32'h8899AABB, 32'h100, lat, writes);
    checkOutput("sw_latency", 32'(lat), 32'd2);
    checkOutput("sw_fault", 32'(rsp_fault), 32'd0);
    checkOutput("sw_writes", 32'(writes), 32'd1);
    checkOutput("sw_wd", last_wd, 32'h8899AABB);
    checkOutput("sw_mem_addr", mem_addr, 32'h10);
    checkOutput("sw_mem_pc", mem_pc, 32'h100);
    checkOutput("sw_rdata", rsp_rdata, 32'h0);
    checkOutput("sw_req_ready", 32'(req_ready), 32'd0);
    releaseResponse();
    checkOutput("sw_back_idle", 32'(req_ready), 32'd1);
    checkOutput("sw_rsp_dropped", 32'(rsp_valid), 32'd0);

    applyStimulus(3'd3, 32'h11, 32'h0, 32'h104, lat, writes);
    checkOutput("lb_latency", 32'(lat), 32'd2);
    checkOutput("lb_rdata", rsp_rdata, 32'hFFFFFFAA);
    checkOutput("lb_fault", 32'(rsp_fault), 32'd0);
    checkOutput("lb_writes", 32'(writes), 32'd0);
    checkOutput("lb_mem_addr", mem_addr, 32'h10);
    releaseResponse();

    applyStimulus(3'd4, 32'h11, 32'h0, 32'h108, lat, writes);
    checkOutput("lbu_rdata", rsp_rdata, 32'h000000AA);
    releaseResponse();
    applyStimulus(3'd1, 32'h12, 32'h0, 32'h10C, lat, writes);
    checkOutput("lh_rdata", rsp_rdata, 32'hFFFF8899);
    releaseResponse();
    applyStimulus(3'd2, 32'h12, 32'h0, 32'h110, lat, writes);
    checkOutput("lhu_rdata", rsp_rdata, 32'h00008899);
    releaseResponse();
    applyStimulus(3'd4, 32'h10, 32'h0, 32'h114, lat, writes);
    checkOutput("lbu_lane0", rsp_rdata, 32'h000000BB);
    releaseResponse();

    applyStimulus(3'd6, 32'h12, 32'h00001234, 32'h118, lat, writes);
    checkOutput("sh_writes", 32'(writes), 32'd1);
    checkOutput("sh_wd", last_wd, 32'h1234AABB);
    releaseResponse();
    applyStimulus(3'd0, 32'h10, 32'h0, 32'h11C, lat, writes);
    checkOutput("lw_after_sh", rsp_rdata, 32'h1234AABB);
    releaseResponse();

    applyStimulus(3'd7, 32'h13, 32'hFFFFFF55, 32'h120, lat, writes);
    checkOutput("sb_writes", 32'(writes), 32'd1);
    checkOutput("sb_wd", last_wd, 32'h5534AABB);
    releaseResponse();
    applyStimulus(3'd3, 32'h13, 32'h0, 32'h124, lat, writes);
    checkOutput("lb_positive", rsp_rdata, 32'h00000055);
    releaseResponse();
    applyStimulus(3'd1, 32'h10, 32'h0, 32'h128, lat, writes);
    checkOutput("lh_lower_sign", rsp_rdata, 32'hFFFFAABB);
    releaseResponse();

    applyStimulus(3'd0, 32'h13, 32'h0, 32'h12C, lat, writes);
    checkOutput("lw_mis_latency", 32'(lat), 32'd1);
    checkOutput("lw_mis_fault", 32'(rsp_fault), 32'd1);
    checkOutput("lw_mis_rdata", rsp_rdata, 32'h0);
    checkOutput("lw_mis_writes", 32'(writes), 32'd0);
    releaseResponse();
    applyStimulus(3'd1, 32'h11, 32'h0, 32'h130, lat, writes);
    checkOutput("lh_mis_fault", 32'(rsp_fault), 32'd1);
    releaseResponse();
    applyStimulus(3'd7, 32'h3000, 32'h000000EE, 32'h134, lat, writes);
    checkOutput("sb_oor_fault", 32'(rsp_fault), 32'd1);
    checkOutput("sb_oor_writes", 32'(writes), 32'd0);
    releaseResponse();
    applyStimulus(3'd5, 32'h2FFC, 32'hCAFEF00D, 32'h138, lat, writes);
    checkOutput("sw_top_fault", 32'(rsp_fault), 32'd0);
    checkOutput("sw_top_writes", 32'(writes), 32'd1);
    checkOutput("sw_top_mem", mem[3071], 32'hCAFEF00D);
    releaseResponse();

    applyStimulus(3'd0, 32'h10, 32'h0, 32'h13C, lat, writes);
    checkOutput("hold_valid_start", 32'(rsp_valid), 32'd1);
    we_snap = we_count;
    held = rsp_rdata;
    checkOutput("hold_rdata_start", held, 32'h5534AABB);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rdata", rsp_rdata, held);
      checkOutput("hold_fault", 32'(rsp_fault), 32'd0);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    releaseResponse();
    repeat (3) @(negedge clk);
    checkOutput("hold_no_queued_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("hold_no_queued_write", 32'(we_count - we_snap), 32'd0);
    checkOutput("hold_rdata_retained", rsp_rdata, 32'h5534AABB);

    we_snap = we_count;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h20; req_wdata = 32'h11111111; req_pc = 32'h200;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_access_we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_access_we_masked", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_access_idle", 32'(req_ready), 32'd1);
    checkOutput("rst_access_no_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("rst_access_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_access_pc", mem_pc, 32'h0);
    checkOutput("rst_access_writes", 32'(we_count - we_snap), 32'd0);
    checkOutput("rst_access_mem", mem[8], 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rst_access_no_late_rsp", 32'(rsp_valid), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
